instr_issue: RTL and testbench

- Front-end issue stage feeding the ALU datapath from board inputs.
- Synchronises and debounces the execute pushbutton, then latches the 16-bit switch word as one instruction {opcode, dest, srcB/imm, srcA}.
- Performs the start/ready handshake with the control FSM and captures the ALU result on the write-enable edge for the display stage.
- Replaces asynchronous key-level sampling with a fully clocked path.

---
 rtl/issue_pkg.sv | 29 ++
 rtl/key_debounce.sv | 62 ++++++
 rtl/instr_issue.sv | 185 ++++++++++++++++++
 tb/tb_instr_issue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the instruction issue stage.
package issue_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;

  // Bit positions of the instruction fields inside the switch word
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPC_MSB    = 11;
  localparam int OPC_LSB    = 8;
  localparam int OPB_MSB    = 7;
  localparam int OPB_LSB    = 4;
  localparam int OPA_MSB    = 3;
  localparam int OPA_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ISSUE    = 2'd2,
    WAIT_WEN = 2'd3
  } issue_state_e;

  // Width that holds the larger of two cycle counts (inclusive)
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each accepted press (debounced 1->0 transition).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_N,
  output logic PRESS
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Debounce decision: count consecutive disagreeing cycles, accept on limit
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q >= CNT_LIMIT) begin
        db_d    = sync2_q;
        cnt_d   = '0;
        // Only the falling (pressed) transition is an event
        press_d = ~sync2_q;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      // Any cycle agreeing with the accepted level restarts the count
      cnt_d = '0;
    end
  end

  // Synchroniser, debounced level, counter and pulse registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= KEY_N;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign PRESS = press_q;

endmodule

// File: rtl/instr_issue.sv
// Issue stage: latches a switch-encoded instruction on a debounced key
// press, handshakes with the control FSM and captures the ALU result.
module instr_issue
  import issue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               KEY_N,
  input  logic [INSTR_W-1:0] SW,
  input  logic               READY,
  input  logic               WEN,
  input  logic [INSTR_W-1:0] RES,
  output logic               START,
  output logic [FIELD_W-1:0] OPCODE,
  output logic [FIELD_W-1:0] OPC,
  output logic [FIELD_W-1:0] OPB,
  output logic [FIELD_W-1:0] OPA,
  output logic [INSTR_W-1:0] RESULT,
  output logic               RESULT_VALID,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  localparam int               CNT_W      = cnt_width(DEBOUNCE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic press_s;

  issue_state_e       state_q, state_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [FIELD_W-1:0] opcode_q, opcode_d;
  logic [FIELD_W-1:0] opc_q, opc_d;
  logic [FIELD_W-1:0] opb_q, opb_d;
  logic [FIELD_W-1:0] opa_q, opa_d;
  logic [INSTR_W-1:0] result_q, result_d;
  logic               rvalid_q, rvalid_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic               wen_q, wen_d;

  logic               wen_rise_s;
  logic [CNT_W-1:0]   to_inc_s;
  logic               to_hit_s;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db (
    .CLK   (CLK),
    .RST   (RST),
    .KEY_N (KEY_N),
    .PRESS (press_s)
  );

  // Edge detect on WEN and saturating timeout increment
  always_comb begin
    wen_rise_s = WEN & ~wen_q;
    if (to_cnt_q != CNT_MAX) begin
      to_inc_s = to_cnt_q + CNT_W'(1);
    end else begin
      to_inc_s = to_cnt_q;
    end
    to_hit_s = (to_inc_s == TO_LIMIT);
  end

  // Next-state and output logic for the issue handshake
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    opc_d    = opc_q;
    opb_d    = opb_q;
    opa_d    = opa_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    terr_d   = terr_q;
    to_cnt_d = to_cnt_q;
    wen_d    = WEN;

    case (state_q)
      IDLE: begin
        if (press_s) begin
          opcode_d = SW[OPCODE_MSB:OPCODE_LSB];
          opc_d    = SW[OPC_MSB:OPC_LSB];
          opb_d    = SW[OPB_MSB:OPB_LSB];
          opa_d    = SW[OPA_MSB:OPA_LSB];
          terr_d   = 1'b0;
          to_cnt_d = '0;
          state_d  = WAIT_RDY;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT_RDY: begin
        to_cnt_d = to_inc_s;
        if (to_hit_s) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (READY) begin
          state_d = ISSUE;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      ISSUE: begin
        to_cnt_d = to_inc_s;
        if (to_hit_s) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (!READY) begin
          state_d = WAIT_WEN;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_WEN: begin
        to_cnt_d = to_inc_s;
        // A capture in the same cycle as the timeout takes priority
        if (wen_rise_s) begin
          result_d = RES;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (to_hit_s) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_WEN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // START and BUSY are registered copies of the upcoming state
    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      opcode_q <= '0;
      opc_q    <= '0;
      opb_q    <= '0;
      opa_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      terr_q   <= 1'b0;
      to_cnt_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      opcode_q <= opcode_d;
      opc_q    <= opc_d;
      opb_q    <= opb_d;
      opa_q    <= opa_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      terr_q   <= terr_d;
      to_cnt_q <= to_cnt_d;
      wen_q    <= wen_d;
    end
  end

  assign START        = start_q;
  assign BUSY         = busy_q;
  assign OPCODE       = opcode_q;
  assign OPC          = opc_q;
  assign OPB          = opb_q;
  assign OPA          = opa_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = rvalid_q;
  assign TIMEOUT_ERR  = terr_q;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue with short debounce/timeout settings.
module tb_instr_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        KEY_N;
  logic [15:0] SW;
  logic        READY;
  logic        WEN;
  logic [15:0] RES;
  logic        START;
  logic [3:0]  OPCODE, OPC, OPB, OPA;
  logic [15:0] RESULT;
  logic        RESULT_VALID;
  logic        BUSY;
  logic        TIMEOUT_ERR;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  instr_issue #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .KEY_N        (KEY_N),
    .SW           (SW),
    .READY        (READY),
    .WEN          (WEN),
    .RES          (RES),
    .START        (START),
    .OPCODE       (OPCODE),
    .OPC          (OPC),
    .OPB          (OPB),
    .OPA          (OPA),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .BUSY         (BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold the key long enough for one accepted press; returns in the event cycle
  task automatic press();
    KEY_N = 1'b0;
    cyc(6);
    chk("press_evt", 32'(dut.u_db.PRESS), 32'd1);
    KEY_N = 1'b1;
  endtask

  // Scoreboard: every RESULT_VALID pulse must match the oldest expected result
  always @(negedge CLK) begin
    if (RESULT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        chk("sb_result", 32'(RESULT), 32'(exp_v));
      end
    end
  end

  initial begin
    logic [13:0] bpat;
    int          pcnt;
    int          pat;

    RST = 1'b1; KEY_N = 1'b1; READY = 1'b0; WEN = 1'b0; SW = 16'h0000; RES = 16'h0000;
    cyc(3);
    chk("rst_ctrl", 32'({START, BUSY, RESULT_VALID, TIMEOUT_ERR}), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_fields", 32'({OPCODE, OPC, OPB, OPA}), 32'd0);
    RST = 1'b0;
    cyc(2);

    // Bounce: 0,0,1,1 then held low; final fall applied at step 4
    bpat = 14'b00_0000_0000_1100;
    pcnt = 0;
    pat  = -1;
    for (int i = 0; i < 14; i++) begin
      KEY_N = bpat[i];
      cyc(1);
      if (dut.u_db.PRESS === 1'b1) begin
        pcnt++;
        pat = i;
      end
    end
    chk("bounce_count", 32'(pcnt), 32'd1);
    chk("bounce_at", 32'(pat), 32'd9);
    chk("bounce_busy", 32'(BUSY), 32'd1);
    pcnt = 0;
    for (int i = 0; i < 10; i++) begin
      KEY_N = 1'b1;
      cyc(1);
      if (dut.u_db.PRESS === 1'b1) pcnt++;
    end
    chk("release_none", 32'(pcnt), 32'd0);
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    cyc(1);

    // Normal issue
    SW = 16'h1A53; READY = 1'b1;
    press();
    cyc(1);
    chk("norm_fields", 32'({OPCODE, OPC, OPB, OPA}), 32'h1A53);
    chk("norm_start_n1", 32'(START), 32'd0);
    chk("norm_busy", 32'(BUSY), 32'd1);
    cyc(1);
    chk("norm_start_n2", 32'(START), 32'd1);
    READY = 1'b0;
    cyc(1);
    chk("norm_start_drop", 32'(START), 32'd0);
    chk("norm_busy_wen", 32'(BUSY), 32'd1);
    RES = 16'h00F7; WEN = 1'b1; exp_q.push_back(16'h00F7);
    cyc(1);
    chk("norm_rv", 32'(RESULT_VALID), 32'd1);
    chk("norm_result", 32'(RESULT), 32'h00F7);
    chk("norm_busy_done", 32'(BUSY), 32'd0);
    cyc(1);
    chk("norm_rv_pulse", 32'(RESULT_VALID), 32'd0);
    chk("norm_terr", 32'(TIMEOUT_ERR), 32'd0);
    WEN = 1'b0;
    cyc(4);

    // Backpressure: READY low for 5 cycles after the press
    SW = 16'h2B64; READY = 1'b0;
    press();
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk("bp_start_low", 32'(START), 32'd0);
      chk("bp_busy", 32'(BUSY), 32'd1);
    end
    READY = 1'b1;
    cyc(1);
    chk("bp_start_rise", 32'(START), 32'd1);
    chk("bp_fields", 32'({OPCODE, OPC, OPB, OPA}), 32'h2B64);
    READY = 1'b0;
    cyc(1);
    chk("bp_start_drop", 32'(START), 32'd0);
    RES = 16'h1234; WEN = 1'b1; exp_q.push_back(16'h1234);
    cyc(1);
    chk("bp_rv", 32'(RESULT_VALID), 32'd1);
    WEN = 1'b0;
    cyc(4);

    // Timeout: READY never drops while START is high
    SW = 16'h1A53; READY = 1'b1;
    press();
    cyc(2);
    chk("to_start", 32'(START), 32'd1);
    cyc(13);
    chk("to_not_yet", 32'(TIMEOUT_ERR), 32'd0);
    chk("to_start_hold", 32'(START), 32'd1);
    cyc(1);
    chk("to_err", 32'(TIMEOUT_ERR), 32'd1);
    chk("to_start_off", 32'(START), 32'd0);
    chk("to_busy", 32'(BUSY), 32'd0);
    chk("to_result_keep", 32'(RESULT), 32'h1234);
    READY = 1'b0;
    cyc(2);

    // Next press clears the error; a press during WAIT_WEN is dropped
    SW = 16'h1A53; READY = 1'b1;
    press();
    cyc(1);
    chk("clr_terr", 32'(TIMEOUT_ERR), 32'd0);
    cyc(1);
    chk("drop_start", 32'(START), 32'd1);
    READY = 1'b0;
    cyc(1);
    chk("drop_wait_wen", 32'({START, BUSY}), 32'h1);
    cyc(3);
    SW = 16'hFFFF;
    press();
    cyc(1);
    chk("drop_fields", 32'({OPCODE, OPC, OPB, OPA}), 32'h1A53);
    chk("drop_busy", 32'(BUSY), 32'd1);
    RES = 16'hBEEF; WEN = 1'b1; exp_q.push_back(16'hBEEF);
    cyc(1);
    chk("drop_rv", 32'(RESULT_VALID), 32'd1);
    chk("drop_result", 32'(RESULT), 32'hBEEF);
    chk("drop_terr", 32'(TIMEOUT_ERR), 32'd0);
    WEN = 1'b0;
    cyc(8);

    // Reset while START is asserted
    SW = 16'h1A53; READY = 1'b1;
    press();
    cyc(2);
    chk("mid_start", 32'(START), 32'd1);
    RST = 1'b1;
    cyc(1);
    chk("mid_ctrl", 32'({START, BUSY, RESULT_VALID, TIMEOUT_ERR}), 32'd0);
    chk("mid_result", 32'(RESULT), 32'd0);
    chk("mid_fields", 32'({OPCODE, OPC, OPB, OPA}), 32'd0);
    RST = 1'b0; READY = 1'b0; RES = 16'h5555; WEN = 1'b1;
    cyc(3);
    chk("mid_wen_ignored", 32'(RESULT), 32'd0);
    chk("mid_idle", 32'(BUSY), 32'd0);
    WEN = 1'b0;
    cyc(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
